// File: rtl/knob_conditioner_if.sv
// Conditioner bus: sample strobe and raw levels in; conditioned levels and status out.
interface knob_conditioner_if #(
    parameter int NUM_KNOBS  = 8,
    parameter int KNOB_WIDTH = 8
);
    logic                                   sample_tick_i;
    logic [NUM_KNOBS-1:0][KNOB_WIDTH-1:0]   knob_level_i;
    logic [NUM_KNOBS-1:0][KNOB_WIDTH-1:0]   knob_level_o;
    logic [NUM_KNOBS-1:0]                   knob_change_o;
    logic                                   busy_o;
    logic                                   overrun_o;

    modport master (
        output sample_tick_i,
        output knob_level_i,
        input  knob_level_o,
        input  knob_change_o,
        input  busy_o,
        input  overrun_o
    );

    modport slave (
        input  sample_tick_i,
        input  knob_level_i,
        output knob_level_o,
        output knob_change_o,
        output busy_o,
        output overrun_o
    );
endinterface

// File: rtl/knob_conditioner.sv
// Per-channel hysteresis and optional slew limiting, one channel per clock after each sample tick.
// Optional slew limiting is enabled by defining KNOB_CONDITIONER_SLEW_EN.
//
// state | meaning
// IDLE  | waiting for sample_tick_i; snapshot taken on the tick
// SCAN  | processing channel idx, one per clock, 0..NUM_KNOBS-1
module knob_conditioner #(
    parameter int NUM_KNOBS  = 8,
    parameter int KNOB_WIDTH = 8,
    parameter int HYST       = 2,
    parameter int STEP       = 1
) (
    input  logic             clk_i,
    input  logic             arst_i,
    knob_conditioner_if.slave bus
);
    localparam int IDX_W = (NUM_KNOBS > 1) ? $clog2(NUM_KNOBS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_KNOBS - 1);
    localparam logic [KNOB_WIDTH-1:0] FULL     = '1;
    localparam logic [KNOB_WIDTH:0]   HYST_W   = (KNOB_WIDTH + 1)'(HYST);

`ifdef KNOB_CONDITIONER_SLEW_EN
    localparam int SLEW_LIMIT = STEP;
`else
    // Limit at or above full scale: the output reaches its target in a single step.
    localparam int SLEW_LIMIT = (STEP > 2**KNOB_WIDTH) ? STEP : 2**KNOB_WIDTH;
`endif
    localparam logic [KNOB_WIDTH:0]   LIMIT_W = (KNOB_WIDTH + 1)'(SLEW_LIMIT);
    localparam logic [KNOB_WIDTH-1:0] STEP_K  = KNOB_WIDTH'(SLEW_LIMIT);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]                     idx_q;
    logic [NUM_KNOBS-1:0][KNOB_WIDTH-1:0] snap_q;
    logic [NUM_KNOBS-1:0][KNOB_WIDTH-1:0] target_q;
    logic [NUM_KNOBS-1:0][KNOB_WIDTH-1:0] level_q;
    logic [NUM_KNOBS-1:0]                 change_q;
    logic                                 busy_q;
    logic                                 overrun_q;

    logic load_snap;
    logic step_en;
    logic last_step;
    logic overrun_set;
    logic busy_d;

    logic [KNOB_WIDTH-1:0] cur_snap;
    logic [KNOB_WIDTH-1:0] cur_tgt;
    logic [KNOB_WIDTH-1:0] cur_out;
    logic [KNOB_WIDTH-1:0] new_tgt;
    logic [KNOB_WIDTH-1:0] new_out;
    logic [KNOB_WIDTH:0]   hyst_diff;
    logic [KNOB_WIDTH:0]   slew_diff;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.sample_tick_i) state_d = SCAN;
            SCAN: if (idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_snap   = 1'b0;
        step_en     = 1'b0;
        last_step   = 1'b0;
        overrun_set = 1'b0;
        busy_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_snap = bus.sample_tick_i;
                busy_d    = bus.sample_tick_i;
            end
            SCAN: begin
                step_en     = 1'b1;
                last_step   = (idx_q == LAST_IDX);
                // Ticks are dropped while scanning, including on the last channel.
                overrun_set = bus.sample_tick_i;
                busy_d      = (idx_q != LAST_IDX);
            end
            default: ;
        endcase
    end

    // Datapath for the addressed channel; the fresh target feeds the output directly.
    always_comb begin
        cur_snap = snap_q[idx_q];
        cur_tgt  = target_q[idx_q];
        cur_out  = level_q[idx_q];

        if (cur_snap >= cur_tgt) hyst_diff = {1'b0, cur_snap} - {1'b0, cur_tgt};
        else                     hyst_diff = {1'b0, cur_tgt} - {1'b0, cur_snap};

        new_tgt = cur_tgt;
        if (cur_snap == '0 || cur_snap == FULL || hyst_diff > HYST_W) new_tgt = cur_snap;

        if (new_tgt >= cur_out) slew_diff = {1'b0, new_tgt} - {1'b0, cur_out};
        else                    slew_diff = {1'b0, cur_out} - {1'b0, new_tgt};

        new_out = new_tgt;
        if (slew_diff > LIMIT_W) begin
            new_out = (new_tgt > cur_out) ? (cur_out + STEP_K) : (cur_out - STEP_K);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            idx_q  <= '0;
            snap_q <= '0;
        end else begin
            if (load_snap) begin
                snap_q <= bus.knob_level_i;
                idx_q  <= '0;
            end else if (step_en) begin
                idx_q <= last_step ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            target_q <= '0;
            level_q  <= '0;
            change_q <= '0;
        end else begin
            change_q <= '0;
            if (step_en) begin
                target_q[idx_q] <= new_tgt;
                level_q[idx_q]  <= new_out;
                change_q[idx_q] <= (new_out != cur_out);
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (overrun_set) overrun_q <= 1'b1;
        end
    end

    assign bus.knob_level_o  = level_q;
    assign bus.knob_change_o = change_q;
    assign bus.busy_o        = busy_q;
    assign bus.overrun_o     = overrun_q;
endmodule

// File: tb/tb_knob_conditioner.sv
// Directed bench for knob_conditioner with a tick-level behavioural model compared every cycle.
module tb_knob_conditioner;
    localparam int N    = 8;
    localparam int W    = 8;
    localparam int HYST = 2;
    localparam int STEP = 1;
`ifdef KNOB_CONDITIONER_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic arst_i;
    always #20 clk_i = ~clk_i;

    knob_conditioner_if #(.NUM_KNOBS(N), .KNOB_WIDTH(W)) kif ();

    knob_conditioner #(.NUM_KNOBS(N), .KNOB_WIDTH(W), .HYST(HYST), .STEP(STEP)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (kif)
    );

    int total = 0;
    int bad   = 0;

    int m_tgt [N];
    int m_pend[N];
    int m_out [N];
    bit [N-1:0] m_chg;
    bit m_busy;
    bit m_ovr;
    int m_phase;
    int cnt0 = 0;
    int cnt3 = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int hyst_target(input int s, input int t);
        int d;
        d = (s > t) ? s - t : t - s;
        if (s == 0 || s == 2**W - 1 || d > HYST) return s;
        return t;
    endfunction

    function automatic int slew_out(input int tgt, input int o);
        if (!SLEW) return tgt;
        if (tgt > o) return (tgt - o > STEP) ? o + STEP : tgt;
        if (o > tgt) return (o - tgt > STEP) ? o - STEP : tgt;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_tgt[i]  = 0;
            m_pend[i] = 0;
            m_out[i]  = 0;
        end
        m_chg   = '0;
        m_busy  = 1'b0;
        m_ovr   = 1'b0;
        m_phase = 0;
    endtask

    // Model: a tick resolves every channel at once; results are released one per edge.
    task automatic model_edge();
        int ch;
        if (arst_i) begin
            model_reset();
            return;
        end
        m_chg = '0;
        if (m_phase > 0) begin
            ch = m_phase - 1;
            m_chg[ch] = (m_pend[ch] != m_out[ch]);
            m_out[ch] = m_pend[ch];
            if (kif.sample_tick_i) m_ovr = 1'b1;
            m_phase = (m_phase == N) ? 0 : m_phase + 1;
        end else if (kif.sample_tick_i) begin
            for (int i = 0; i < N; i++) begin
                m_tgt[i]  = hyst_target(int'(kif.knob_level_i[i]), m_tgt[i]);
                m_pend[i] = slew_out(m_tgt[i], m_out[i]);
            end
            m_phase = 1;
        end
        m_busy = (m_phase != 0);
    endtask

    initial begin
        logic [N*W-1:0] exp_lvl;
        model_reset();
        forever begin
            @(posedge clk_i);
            model_edge();
            @(negedge clk_i);
            if (arst_i) model_reset();
            for (int i = 0; i < N; i++) exp_lvl[i*W +: W] = W'(m_out[i]);
            check("level", longint'(kif.knob_level_o), longint'(exp_lvl));
            check("change", longint'(kif.knob_change_o), longint'(m_chg));
            check("busy", longint'(kif.busy_o), longint'(m_busy));
            check("overrun", longint'(kif.overrun_o), longint'(m_ovr));
            if (kif.knob_change_o[0]) cnt0++;
            if (kif.knob_change_o[3]) cnt3++;
        end
    end

    task automatic scan();
        @(negedge clk_i);
        kif.sample_tick_i = 1'b1;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b0;
        repeat (N + 1) @(negedge clk_i);
    endtask

    task automatic settle(input int ch);
        int k;
        k = 0;
        do begin
            scan();
            k++;
        end while (m_out[ch] != int'(kif.knob_level_i[ch]) && k < 300);
        check("settle_in_time", longint'(k < 300), 1);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        kif.sample_tick_i = 1'b0;
        kif.knob_level_i  = '0;
        arst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        check("rst_level", longint'(kif.knob_level_o), 0);
        check("rst_busy", longint'(kif.busy_o), 0);
        check("rst_overrun", longint'(kif.overrun_o), 0);

        // Channel timing after a single tick.
        for (int i = 0; i < N; i++) kif.knob_level_i[i] = W'(10 * (i + 1));
        @(negedge clk_i);
        kif.sample_tick_i = 1'b1;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b0;
        for (int k = 0; k <= N; k++) begin
            check("t5_busy", longint'(kif.busy_o), (k < N) ? 1 : 0);
            check("t5_change", longint'(kif.knob_change_o), (k == 0) ? 0 : (1 << (k - 1)));
            check("t5_knob7", longint'(kif.knob_level_o[7]), (k == N) ? (SLEW ? 1 : 80) : 0);
            @(negedge clk_i);
        end

        // Jitter inside the dead band.
        kif.knob_level_i[0] = 8'd100;
        settle(0);
        base = cnt0;
        for (int k = 0; k < 50; k++) begin
            kif.knob_level_i[0] = W'(100 + (k % 3));
            scan();
        end
        check("t2_level", longint'(kif.knob_level_o[0]), 100);
        check("t2_pulses", longint'(cnt0 - base), 0);

        // Step response on knob3.
        kif.knob_level_i[3] = 8'd0;
        settle(3);
        base = cnt3;
        kif.knob_level_i[3] = 8'd10;
        for (int k = 1; k <= 10; k++) begin
            scan();
            check("t3_level", longint'(kif.knob_level_o[3]), SLEW ? k : 10);
        end
        check("t3_pulses", longint'(cnt3 - base), SLEW ? 10 : 1);

        // Endpoints snap even inside the dead band.
        kif.knob_level_i[5] = 8'd254;
        settle(5);
        kif.knob_level_i[5] = 8'd255;
        scan();
        check("t4_full", longint'(kif.knob_level_o[5]), 255);
        kif.knob_level_i[5] = 8'd1;
        settle(5);
        kif.knob_level_i[5] = 8'd0;
        scan();
        check("t4_zero", longint'(kif.knob_level_o[5]), 0);

        // Overrun: second tick four cycles into the scan.
        kif.knob_level_i[1] = 8'd200;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b1;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b0;
        repeat (3) @(negedge clk_i);
        kif.sample_tick_i = 1'b1;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b0;
        check("t6_overrun", longint'(kif.overrun_o), 1);
        check("t6_busy", longint'(kif.busy_o), 1);
        repeat (14) @(negedge clk_i);
        check("t6_level1", longint'(kif.knob_level_o[1]), SLEW ? 21 : 200);
        kif.knob_level_i[1] = 8'd150;
        scan();
        check("t6_level1_b", longint'(kif.knob_level_o[1]), SLEW ? 22 : 150);
        check("t6_sticky", longint'(kif.overrun_o), 1);

        // Reset on the third SCAN cycle.
        @(negedge clk_i);
        kif.sample_tick_i = 1'b1;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 arst_i = 1'b1;
        #1;
        check("t1_level", longint'(kif.knob_level_o), 0);
        check("t1_busy", longint'(kif.busy_o), 0);
        check("t1_overrun", longint'(kif.overrun_o), 0);
        check("t1_change", longint'(kif.knob_change_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b1;
        @(negedge clk_i);
        kif.sample_tick_i = 1'b0;
        @(negedge clk_i);
        check("t1_first_ch", longint'(kif.knob_change_o), 1);
        repeat (N + 1) @(negedge clk_i);
        check("t1_busy_end", longint'(kif.busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
